// File: rtl/accu_stim_driver.sv
// Table-driven stimulus/check sequencer for accu_top: drives in/next per step,
// waits a settle window, compares out/state_display and tallies mismatches.
module accu_stim_driver #(
  parameter  int WIDTH    = 8,
  parameter  int STATE_W  = 4,
  parameter  int DEPTH    = 8,
  parameter  int NEXT_CYC = 1,
  parameter  int SETTLE   = 50,
  localparam int IDX_W    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tbl_we,
  input  logic [IDX_W-1:0]   tbl_addr,
  input  logic [WIDTH-1:0]   tbl_in,
  input  logic [WIDTH-1:0]   tbl_exp_out,
  input  logic [STATE_W-1:0] tbl_exp_state,
  input  logic [IDX_W:0]     num_steps,
  input  logic               start,
  input  logic [WIDTH-1:0]   obs_out,
  input  logic [STATE_W-1:0] obs_state,
  output logic [WIDTH-1:0]   stim_in,
  output logic               stim_next,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [IDX_W:0]     err_count,
  output logic [IDX_W-1:0]   first_fail
);

  localparam int CNT_MAX = (NEXT_CYC > SETTLE) ? NEXT_CYC : SETTLE;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [IDX_W:0]   DEPTH_V   = (IDX_W+1)'(DEPTH);
  localparam logic [CNT_W-1:0] NEXT_LAST = CNT_W'(NEXT_CYC - 1);
  localparam logic [CNT_W-1:0] SETL_LAST = CNT_W'(SETTLE - 1);

  typedef struct packed {
    logic [WIDTH-1:0]   stim;
    logic [WIDTH-1:0]   exp_out;
    logic [STATE_W-1:0] exp_state;
  } entry_t;

  typedef enum logic [2:0] {
    S_IDLE, S_DRIVE, S_SETTLE, S_CHECK, S_DONE
  } state_t;

  state_t           state;
  entry_t           tbl [DEPTH];
  logic [IDX_W-1:0] step, last_step, step_nxt;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W:0]   n_eff, err_nxt;
  logic [WIDTH-1:0] first_stim;
  logic             mismatch;

  // Table is deliberately outside the reset domain so contents survive reset.
  always_ff @(posedge clk) begin
    if (tbl_we && !busy)
      tbl[tbl_addr] <= '{stim: tbl_in, exp_out: tbl_exp_out, exp_state: tbl_exp_state};
  end

  always_comb begin
    n_eff      = (num_steps > DEPTH_V) ? DEPTH_V : num_steps;
    // A write landing on entry 0 in the start cycle must be seen by step 0.
    first_stim = (tbl_we && tbl_addr == '0) ? tbl_in : tbl[0].stim;
    step_nxt   = step + 1'b1;
    mismatch   = (obs_out != tbl[step].exp_out) || (obs_state != tbl[step].exp_state);
    err_nxt    = err_count;
    if (mismatch && err_count != '1)
      err_nxt = err_count + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      stim_in    <= '0;
      stim_next  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      first_fail <= '0;
      step       <= '0;
      last_step  <= '0;
      cnt        <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            err_count  <= '0;
            first_fail <= '0;
            step       <= '0;
            cnt        <= '0;
            last_step  <= IDX_W'(n_eff - 1'b1);
            if (n_eff == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
              pass  <= 1'b1;
            end else begin
              state     <= S_DRIVE;
              done      <= 1'b0;
              pass      <= 1'b0;
              busy      <= 1'b1;
              stim_in   <= first_stim;
              stim_next <= 1'b1;
            end
          end
        end
        S_DRIVE: begin
          if (cnt == NEXT_LAST) begin
            stim_next <= 1'b0;
            cnt       <= '0;
            state     <= S_SETTLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_SETTLE: begin
          if (cnt == SETL_LAST) begin
            cnt   <= '0;
            state <= S_CHECK;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_CHECK: begin
          err_count <= err_nxt;
          if (mismatch && err_count == '0)
            first_fail <= step;
          if (step == last_step) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_nxt == '0);
          end else begin
            step      <= step_nxt;
            state     <= S_DRIVE;
            stim_in   <= tbl[step_nxt].stim;
            stim_next <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_accu_stim_driver.sv
// Random table runs against a behavioural accu_top responder; a scoreboard
// predicts every next pulse and each run's verdict from the loaded table.
module tb_accu_stim_driver;
  localparam int WIDTH = 8, STATE_W = 4, DEPTH = 8, NEXT_CYC = 1, SETTLE = 50;
  localparam int IDX_W = 3;
  localparam int L = NEXT_CYC + SETTLE + 1;

  logic               clk = 0, reset = 1, tbl_we = 0, start = 0;
  logic [IDX_W-1:0]   tbl_addr = 0;
  logic [WIDTH-1:0]   tbl_in = 0, tbl_exp_out = 0;
  logic [STATE_W-1:0] tbl_exp_state = 0;
  logic [IDX_W:0]     num_steps = 0;
  logic [WIDTH-1:0]   obs_out = 0;
  logic [STATE_W-1:0] obs_state = 0;
  logic [WIDTH-1:0]   stim_in;
  logic               stim_next, busy, done, pass;
  logic [IDX_W:0]     err_count;
  logic [IDX_W-1:0]   first_fail;

  accu_stim_driver #(.WIDTH(WIDTH), .STATE_W(STATE_W), .DEPTH(DEPTH),
                     .NEXT_CYC(NEXT_CYC), .SETTLE(SETTLE)) dut (
    .clk(clk), .reset(reset), .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_in(tbl_in),
    .tbl_exp_out(tbl_exp_out), .tbl_exp_state(tbl_exp_state), .num_steps(num_steps),
    .start(start), .obs_out(obs_out), .obs_state(obs_state), .stim_in(stim_in),
    .stim_next(stim_next), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_fail(first_fail));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // reference state: table contents and the accu_top model (sum of in, pulse count)
  logic [WIDTH-1:0]   m_stim [DEPTH];
  logic [WIDTH-1:0]   m_out  [DEPTH];
  logic [STATE_W-1:0] m_st   [DEPTH];
  logic [WIDTH-1:0]   m_acc = 0;
  logic [STATE_W-1:0] m_cnt = 0;

  always @(negedge clk) begin
    if (stim_next) begin
      m_acc = m_acc + stim_in;
      m_cnt = m_cnt + 1'b1;
    end
    obs_out   = m_acc;
    obs_state = m_cnt;
  end

  typedef struct { int cyc; logic [WIDTH-1:0] val; } stim_exp_t;
  typedef struct { int issue; int done_cyc; int pass; int err; int ff; } res_exp_t;
  stim_exp_t stim_q[$];
  res_exp_t  res_q[$];

  int n_chk = 0, n_pass = 0;

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
  endtask

  // monitor: pops expectations whenever the DUT presents a pulse or a finished run
  logic prev_next = 0;
  int   rise_cyc  = 0;
  stim_exp_t se_m;
  res_exp_t  re_m;
  always @(negedge clk) begin
    if (!reset) begin
      if (stim_next && !prev_next) begin
        rise_cyc = cyc;
        if (stim_q.size() == 0) check("unexpected_next", int'(stim_next), 0);
        else begin
          se_m = stim_q.pop_front();
          check("next_rise_cycle", cyc, se_m.cyc);
          check("stim_in", int'(stim_in), int'(se_m.val));
        end
      end
      if (!stim_next && prev_next) check("next_width", cyc - rise_cyc, NEXT_CYC);
      if (res_q.size() > 0 && cyc > res_q[0].issue) begin
        if (done) begin
          re_m = res_q.pop_front();
          check("done_cycle", cyc, re_m.done_cyc);
          check("pass", int'(pass), re_m.pass);
          check("err_count", int'(err_count), re_m.err);
          check("first_fail", int'(first_fail), re_m.ff);
          check("busy_at_done", int'(busy), 0);
          check("pulses_left", stim_q.size(), 0);
          stim_q.delete();
        end else if (cyc > res_q[0].done_cyc + 10) begin
          check("done_seen", int'(done), 1);
          void'(res_q.pop_front());
          stim_q.delete();
        end
      end
    end
    prev_next = stim_next;
  end

  // predict a run straight from the table and the accu model's current state
  task automatic push_expect(input int n_raw);
    int n, err, ff;
    logic [WIDTH-1:0]   acc;
    logic [STATE_W-1:0] cnt;
    stim_exp_t se;
    res_exp_t  re;
    n = (n_raw > DEPTH) ? DEPTH : n_raw;
    acc = m_acc; cnt = m_cnt; err = 0; ff = 0;
    for (int i = 0; i < n; i++) begin
      se.cyc = cyc + 1 + i * L;
      se.val = m_stim[i];
      stim_q.push_back(se);
      acc = acc + WIDTH'(NEXT_CYC * int'(m_stim[i]));
      cnt = cnt + STATE_W'(NEXT_CYC);
      if (acc != m_out[i] || cnt != m_st[i]) begin
        if (err == 0) ff = i;
        err++;
      end
    end
    re.issue = cyc; re.done_cyc = cyc + 1 + n * L;
    re.pass = (err == 0); re.err = err; re.ff = ff;
    res_q.push_back(re);
  endtask

  task automatic tbl_write(input int a, input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] o,
                           input logic [STATE_W-1:0] st, input bit dropped);
    @(negedge clk);
    tbl_we = 1; tbl_addr = IDX_W'(a); tbl_in = s; tbl_exp_out = o; tbl_exp_state = st;
    if (!dropped) begin m_stim[a] = s; m_out[a] = o; m_st[a] = st; end
    @(negedge clk);
    tbl_we = 0;
  endtask

  task automatic load_matching(input int n);
    logic [WIDTH-1:0]   acc, s;
    logic [STATE_W-1:0] cnt;
    acc = m_acc; cnt = m_cnt;
    for (int i = 0; i < n; i++) begin
      s   = WIDTH'($urandom);
      acc = acc + WIDTH'(NEXT_CYC * int'(s));
      cnt = cnt + STATE_W'(NEXT_CYC);
      tbl_write(i, s, acc, cnt, 0);
    end
  endtask

  task automatic do_start(input int n, input bit expect_run);
    @(negedge clk);
    num_steps = (IDX_W+1)'(n); start = 1;
    if (expect_run) push_expect(n);
    @(negedge clk);
    start = 0;
  endtask

  task automatic wait_runs();
    int k = 0;
    while (res_q.size() != 0 && k < 5000) begin @(negedge clk); k++; end
    if (res_q.size() != 0) begin
      check("run_finished", int'(done), 1);
      res_q.delete(); stim_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) begin m_stim[i] = 0; m_out[i] = 0; m_st[i] = 0; end
    repeat (3) @(negedge clk);
    check("rst_stim_next", int'(stim_next), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_pass", int'(pass), 0);
    check("rst_stim_in", int'(stim_in), 0);
    check("rst_err", int'(err_count), 0);
    reset = 0;
    // table written before reset must survive it
    load_matching(DEPTH);
    reset = 1; @(negedge clk); reset = 0;

    // clean 3-step run
    load_matching(3);
    do_start(3, 1); wait_runs();
    check("clean_pass", int'(pass), 1);

    // corrupt entry 1 exp_out and entry 2 exp_state
    load_matching(3);
    tbl_write(1, m_stim[1], m_out[1] + 1'b1, m_st[1], 0);
    tbl_write(2, m_stim[2], m_out[2], m_st[2] ^ 4'h1, 0);
    do_start(3, 1); wait_runs();
    check("corrupt_err", int'(err_count), 2);
    check("corrupt_ff", int'(first_fail), 1);

    // zero-length run
    do_start(0, 1); wait_runs();

    // writes and start while busy are ignored; restart from DONE reruns
    load_matching(3);
    tbl_write(0, m_stim[0], m_out[0] ^ 8'h80, m_st[0], 0);
    do_start(3, 1);
    repeat (20) @(negedge clk);
    tbl_write(0, 8'h5a, 8'h11, 4'h3, 1);
    do_start(1, 0);
    tbl_write(1, 8'ha5, 8'h22, 4'h4, 1);
    wait_runs();
    load_matching(3);
    do_start(3, 1); wait_runs();
    check("rerun_err_cleared", int'(err_count), 0);

    // full depth and clamped length
    load_matching(DEPTH);
    do_start(DEPTH, 1); wait_runs();
    load_matching(DEPTH);
    do_start(12, 1); wait_runs();

    // write to entry 0 in the same cycle as start
    load_matching(2);
    @(negedge clk);
    tbl_we = 1; tbl_addr = 0; tbl_in = 8'h3c;
    tbl_exp_out = m_acc + 8'h3c; tbl_exp_state = m_cnt + 1'b1;
    m_stim[0] = 8'h3c; m_out[0] = m_acc + 8'h3c; m_st[0] = m_cnt + 1'b1;
    num_steps = 2; start = 1;
    push_expect(2);
    @(negedge clk);
    tbl_we = 0; start = 0;
    wait_runs();

    // async reset in the middle of a settle window
    load_matching(3);
    do_start(3, 1);
    repeat (10) @(negedge clk);
    reset = 1;
    #1;
    check("midrst_stim_next", int'(stim_next), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_stim_in", int'(stim_in), 0);
    res_q.delete(); stim_q.delete();
    @(negedge clk); reset = 0;
    do_start(3, 1); wait_runs();

    // randomized runs with random corruption and lengths
    for (int r = 0; r < 6; r++) begin
      int idx;
      load_matching(DEPTH);
      idx = $urandom_range(0, DEPTH - 1);
      if ($urandom_range(0, 1) == 1)
        tbl_write(idx, m_stim[idx], m_out[idx] ^ WIDTH'($urandom_range(1, 255)), m_st[idx], 0);
      idx = $urandom_range(0, DEPTH - 1);
      if ($urandom_range(0, 1) == 1)
        tbl_write(idx, m_stim[idx], m_out[idx], m_st[idx] ^ STATE_W'($urandom_range(1, 15)), 0);
      do_start($urandom_range(0, 15), 1); wait_runs();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
